// File: rtl/eager_fork_data.sv
// Eager fork: one input token is broadcast to SIZE branches, and each branch
// takes it independently. The input retires once every branch has taken it.
module eager_fork_data #(
    parameter int unsigned SIZE       = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      ins,
    input  logic                       ins_valid,
    output logic                       ins_ready,
    output logic [SIZE*DATA_WIDTH-1:0] outs,
    output logic [SIZE-1:0]            outs_valid,
    input  logic [SIZE-1:0]            outs_ready
);

    logic [SIZE-1:0] r_sent;
    logic [SIZE-1:0] w_done;
    logic [SIZE-1:0] w_xfer;

    assign outs       = {SIZE{ins}};
    assign outs_valid = {SIZE{ins_valid}} & ~r_sent;
    assign w_xfer     = outs_valid & outs_ready;
    // ins_ready is built only from sent and outs_ready, so it has no path from ins_valid
    assign w_done     = r_sent | outs_ready;
    assign ins_ready  = &w_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sent <= '0;
        end else if (ins_valid && ins_ready) begin
            r_sent <= '0;
        end else begin
            r_sent <= r_sent | w_xfer;
        end
    end

endmodule

// File: tb/tb_eager_fork_data.sv
// Directed checks of eager_fork_data over several SIZE/DATA_WIDTH configurations,
// plus a scoreboarded random stream on a 4-branch fork.
module tb_eager_fork_data;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // SIZE=3, DATA_WIDTH=32
    logic [31:0] ins3;
    logic        v3, ir3;
    logic [95:0] outs3;
    logic [2:0]  ov3, rdy3;
    // SIZE=2, DATA_WIDTH=32
    logic [31:0] ins2;
    logic        v2, ir2;
    logic [63:0] outs2;
    logic [1:0]  ov2, rdy2;
    // SIZE=4, DATA_WIDTH=16
    logic [15:0] ins4;
    logic        v4, ir4;
    logic [63:0] outs4;
    logic [3:0]  ov4, rdy4;
    // SIZE=1, DATA_WIDTH=8
    logic [7:0]  ins1, outs1;
    logic        v1, ir1, ov1, rdy1;

    eager_fork_data #(.SIZE(3), .DATA_WIDTH(32)) u3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(ir3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(rdy3));
    eager_fork_data #(.SIZE(2), .DATA_WIDTH(32)) u2 (
        .clk(clk), .rst(rst), .ins(ins2), .ins_valid(v2), .ins_ready(ir2),
        .outs(outs2), .outs_valid(ov2), .outs_ready(rdy2));
    eager_fork_data #(.SIZE(4), .DATA_WIDTH(16)) u4 (
        .clk(clk), .rst(rst), .ins(ins4), .ins_valid(v4), .ins_ready(ir4),
        .outs(outs4), .outs_valid(ov4), .outs_ready(rdy4));
    eager_fork_data #(.SIZE(1), .DATA_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .ins(ins1), .ins_valid(v1), .ins_ready(ir1),
        .outs(outs1), .outs_valid(ov1), .outs_ready(rdy1));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] tok [100];
    int unsigned rx [4];
    int unsigned sidx, cyc, accepted;
    logic        holding;
    logic [15:0] exp16;

    initial begin
        ins3 = '0; v3 = 1'b0; rdy3 = '0;
        ins2 = '0; v2 = 1'b0; rdy2 = '0;
        ins4 = '0; v4 = 1'b0; rdy4 = '0;
        ins1 = '0; v1 = 1'b0; rdy1 = '0;

        // reset held: all branches offered, ins_ready = AND of outs_ready
        ins3 = 32'hA5A5A5A5; v3 = 1'b1; rdy3 = 3'b000;
        #1 chk("rst ov3", ov3, 3'b111);
        chk("rst ir3 000", ir3, 1'b0);
        rdy3 = 3'b101;
        #1 chk("rst ir3 101", ir3, 1'b0);
        rdy3 = 3'b111;
        #1 chk("rst ir3 111", ir3, 1'b1);
        @(negedge clk); rst = 1'b1;

        // all ready together: one-cycle retire, sent stays clear
        ins3 = 32'hA5A5A5A5; v3 = 1'b1; rdy3 = 3'b111;
        #1 chk("all ov3", ov3, 3'b111);
        chk("all ir3", ir3, 1'b1);
        chk("all outs3", outs3, {3{32'hA5A5A5A5}});
        @(negedge clk); ins3 = 32'h12345678; rdy3 = 3'b000;
        #1 chk("fresh ov3", ov3, 3'b111);
        chk("fresh ir3", ir3, 1'b0);
        chk("fresh outs3", outs3, {3{32'h12345678}});

        // staggered readiness 001, 100, 010
        ins3 = 32'hA5A5A5A5; rdy3 = 3'b001;
        #1 chk("stag0 ov3", ov3, 3'b111);
        chk("stag0 ir3", ir3, 1'b0);
        @(negedge clk); rdy3 = 3'b100;
        #1 chk("stag1 ov3", ov3, 3'b110);
        chk("stag1 ir3", ir3, 1'b0);
        chk("stag1 outs3", outs3, {3{32'hA5A5A5A5}});
        @(negedge clk); rdy3 = 3'b010;
        #1 chk("stag2 ov3", ov3, 3'b010);
        chk("stag2 ir3", ir3, 1'b1);
        @(negedge clk); rdy3 = 3'b000; ins3 = 32'h0;
        #1 chk("stag retired ov3", ov3, 3'b111);
        v3 = 1'b0;

        // SIZE=2: branch 1 stalls 5 cycles while branch 0 goes once
        ins2 = 32'h11111111; v2 = 1'b1; rdy2 = 2'b01;
        #1 chk("stall0 ov2", ov2, 2'b11);
        chk("stall0 ir2", ir2, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); rdy2 = 2'b01;
            #1 chk("stall ov2", ov2, 2'b10);
            chk("stall ir2", ir2, 1'b0);
        end
        @(negedge clk); rdy2 = 2'b10;
        #1 chk("unstall ov2", ov2, 2'b10);
        chk("unstall ir2", ir2, 1'b1);
        @(negedge clk); rdy2 = 2'b00;
        #1 chk("next ov2", ov2, 2'b11);

        // reset mid-token between edges
        rdy2 = 2'b01;
        @(posedge clk); #2 rdy2 = 2'b00;
        #1 chk("pre-rst ov2", ov2, 2'b10);
        rst = 1'b0;
        #1 chk("async rst ov2", ov2, 2'b11);
        chk("async rst ir2", ir2, 1'b0);
        rdy2 = 2'b11;
        #1 chk("async rst ir2 11", ir2, 1'b1);
        @(negedge clk); rst = 1'b1; rdy2 = 2'b00;
        #1 chk("post-rst ov2", ov2, 2'b11);
        chk("post-rst outs2", outs2, {2{32'h11111111}});
        rdy2 = 2'b11;
        @(negedge clk); v2 = 1'b0; rdy2 = 2'b00;

        // SIZE=1: transparent handshake, half-duty ready
        accepted = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rdy1 = c[0]; v1 = 1'b1; ins1 = 8'(8'h30 + accepted);
            #1 chk("w outs1", outs1, 8'(8'h30 + accepted));
            chk("w ov1", ov1, 1'b1);
            chk("w ir1", ir1, c[0]);
            if (c[0]) accepted++;
        end
        @(negedge clk); v1 = 1'b0; rdy1 = 1'b0;
        #1 chk("w idle ov1", ov1, 1'b0);

        // SIZE=4 random stream, token held until accepted
        for (int k = 0; k < 100; k++) tok[k] = {8'(k), 8'($urandom)};
        for (int i = 0; i < 4; i++) rx[i] = 0;
        sidx = 0; cyc = 0; holding = 1'b0;
        while (sidx < 100 && cyc < 3000) begin
            @(negedge clk);
            if (!holding) v4 = 1'($urandom_range(0, 1));
            ins4 = tok[sidx];
            rdy4 = 4'($urandom);
            #1;
            if (!v4) chk("rnd idle ov4", ov4, 4'b0000);
            for (int i = 0; i < 4; i++) begin
                if (ov4[i] && rdy4[i]) begin
                    exp16 = (rx[i] < 100) ? tok[rx[i]] : 16'hxxxx;
                    chk("rnd data", outs4[i*16 +: 16], exp16);
                    rx[i]++;
                end
            end
            if (v4 && ir4) begin
                for (int i = 0; i < 4; i++) chk("rnd count", rx[i], sidx + 1);
                sidx++;
                holding = 1'b0;
            end else begin
                holding = v4;
            end
            cyc++;
        end
        chk("rnd completed", sidx, 100);
        v4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
